// File: rtl/bram_port_arbiter_if.sv
// Client and BRAM-controller signal bundle for bram_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              i_c0_trig;
  logic [ADDR_W-1:0] i_c0_addr;
  logic [DATA_W-1:0] i_c0_data;
  logic              o_c0_done;
  logic              i_c1_trig;
  logic [ADDR_W-1:0] i_c1_addr;
  logic [DATA_W-1:0] o_c1_data;
  logic              o_c1_done;
  logic              o_bram_trig;
  logic              o_bram_we;
  logic [ADDR_W-1:0] o_bram_addr;
  logic [DATA_W-1:0] o_bram_wdata;
  logic [DATA_W-1:0] i_bram_rdata;
  logic              i_bram_done;
  logic              o_timeout_err;

  modport slave (
    input  i_c0_trig, i_c0_addr, i_c0_data, i_c1_trig, i_c1_addr,
    input  i_bram_rdata, i_bram_done,
    output o_c0_done, o_c1_data, o_c1_done,
    output o_bram_trig, o_bram_we, o_bram_addr, o_bram_wdata, o_timeout_err
  );

  modport master (
    output i_c0_trig, i_c0_addr, i_c0_data, i_c1_trig, i_c1_addr,
    output i_bram_rdata, i_bram_done,
    input  o_c0_done, o_c1_data, o_c1_done,
    input  o_bram_trig, o_bram_we, o_bram_addr, o_bram_wdata, o_timeout_err
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM controller port between a write client (c0) and a read client (c1):
// round-robin on ties, one transaction outstanding, optional ISSUE timeout with a sticky flag.
module bram_port_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic                i_clk,
  input logic                i_rstn,
  bram_port_arbiter_if.slave bus
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;
  state_t state, state_nxt;

  logic             last_c1;
  logic             cur_c1;
  logic             gnt_c1;
  logic             gnt_trig;
  logic             start;
  logic             finish;
  logic             tmo_hit;
  logic [CNT_W-1:0] cnt;

  // On a tie, c1 only wins if c0 was served last.
  assign gnt_c1   = bus.i_c1_trig & (~bus.i_c0_trig | ~last_c1);
  assign gnt_trig = cur_c1 ? bus.i_c1_trig : bus.i_c0_trig;
  assign tmo_hit  = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_c0_trig || bus.i_c1_trig) begin
          start     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.i_bram_done || tmo_hit) begin
          finish    = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!gnt_trig) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      last_c1           <= 1'b1;
      cur_c1            <= 1'b0;
      cnt               <= '0;
      bus.o_bram_trig   <= 1'b0;
      bus.o_bram_we     <= 1'b0;
      bus.o_bram_addr   <= ADDR_W'(0);
      bus.o_bram_wdata  <= DATA_W'(0);
      bus.o_c0_done     <= 1'b0;
      bus.o_c1_done     <= 1'b0;
      bus.o_c1_data     <= '0;
      bus.o_timeout_err <= 1'b0;
    end else begin
      bus.o_c0_done <= 1'b0;
      bus.o_c1_done <= 1'b0;
      if (start) begin
        cur_c1           <= gnt_c1;
        last_c1          <= gnt_c1;
        cnt              <= '0;
        bus.o_bram_trig  <= 1'b1;
        bus.o_bram_we    <= ~gnt_c1;
        bus.o_bram_addr  <= gnt_c1 ? bus.i_c1_addr : bus.i_c0_addr;
        bus.o_bram_wdata <= gnt_c1 ? DATA_W'(0) : bus.i_c0_data;
      end
      // A real completion takes priority over a timeout landing on the same cycle.
      if (finish) begin
        bus.o_bram_trig <= 1'b0;
        if (cur_c1) begin
          bus.o_c1_done <= 1'b1;
          bus.o_c1_data <= bus.i_bram_done ? bus.i_bram_rdata : '0;
        end else begin
          bus.o_c0_done <= 1'b1;
        end
        if (!bus.i_bram_done) begin
          bus.o_timeout_err <= 1'b1;
        end
      end else if (state == ISSUE) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized and directed bench for bram_port_arbiter against a transaction-level model
// (grant order, completion delay = min(latency, TIMEOUT) + 1, sticky error, held read data).
module tb_bram_port_arbiter;
  localparam int AW  = 13;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_last_c1;
  bit          m_err;
  logic [DW-1:0] m_c1_data;

  // client stimulus state
  bit          pend0, pend1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0;
  bit          gnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"},   64'(bus.o_bram_trig),   64'(0));
    check({tag, "_we"},    64'(bus.o_bram_we),     64'(0));
    check({tag, "_addr"},  64'(bus.o_bram_addr),   64'(0));
    check({tag, "_wdata"}, 64'(bus.o_bram_wdata),  64'(0));
    check({tag, "_done0"}, 64'(bus.o_c0_done),     64'(0));
    check({tag, "_done1"}, 64'(bus.o_c1_done),     64'(0));
    check({tag, "_rdata"}, 64'(bus.o_c1_data),     64'(0));
    check({tag, "_err"},   64'(bus.o_timeout_err), 64'(0));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"},   64'(bus.o_bram_trig),                  64'(0));
    check({tag, "_done"},  64'({bus.o_c0_done, bus.o_c1_done}),   64'(0));
    check({tag, "_rdata"}, 64'(bus.o_c1_data),                    64'(m_c1_data));
    check({tag, "_err"},   64'(bus.o_timeout_err),                64'(m_err));
  endtask

  // One arbitrated transaction, entered and left on a negedge with the DUT idle.
  // lat: negedges after the request appears before the BRAM answers (> TMO never answers).
  task automatic run_xact(input int lat, input logic [DW-1:0] rd, input int hold, output bit g1);
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    bit  tmo;
    int  dly;
    bus.i_c0_trig   = pend0;
    bus.i_c1_trig   = pend1;
    bus.i_c0_addr   = a0;
    bus.i_c0_data   = d0;
    bus.i_c1_addr   = a1;
    bus.i_bram_done = 1'b0;
    g1        = (pend0 && pend1) ? !m_last_c1 : pend1;
    m_last_c1 = g1;
    ea  = g1 ? a1 : a0;
    ew  = g1 ? '0 : d0;
    tmo = lat > TMO;
    dly = tmo ? TMO + 1 : lat + 1;
    @(negedge clk);
    for (int k = 0; k < dly; k++) begin
      check("issue_req",   64'(bus.o_bram_trig),                64'(1));
      check("issue_we",    64'(bus.o_bram_we),                  64'(!g1));
      check("issue_addr",  64'(bus.o_bram_addr),                64'(ea));
      check("issue_wdata", 64'(bus.o_bram_wdata),               64'(ew));
      check("issue_done",  64'({bus.o_c0_done, bus.o_c1_done}), 64'(0));
      bus.i_c0_addr    = AW'($urandom);
      bus.i_c0_data    = DW'($urandom);
      bus.i_c1_addr    = AW'($urandom);
      bus.i_bram_done  = (k == lat);
      bus.i_bram_rdata = (k == lat) ? rd : DW'($urandom);
      @(negedge clk);
    end
    if (g1) m_c1_data = tmo ? '0 : rd;
    if (tmo) m_err = 1'b1;
    check("cpl_req",   64'(bus.o_bram_trig),   64'(0));
    check("cpl_done0", 64'(bus.o_c0_done),     64'(!g1));
    check("cpl_done1", 64'(bus.o_c1_done),     64'(g1));
    check("cpl_rdata", 64'(bus.o_c1_data),     64'(m_c1_data));
    check("cpl_err",   64'(bus.o_timeout_err), 64'(m_err));
    for (int h = 0; h < hold; h++) begin
      bus.i_bram_done  = 1'($urandom);
      bus.i_bram_rdata = DW'($urandom);
      @(negedge clk);
      check_quiet("release");
    end
    bus.i_bram_done = 1'b0;
    if (g1) begin
      pend1 = 1'b0;
      bus.i_c1_trig = 1'b0;
    end else begin
      pend0 = 1'b0;
      bus.i_c0_trig = 1'b0;
    end
    @(negedge clk);
    check_quiet("drop");
  endtask

  task automatic idle_spur();
    bus.i_bram_done  = 1'b1;
    bus.i_bram_rdata = DW'($urandom);
    @(negedge clk);
    bus.i_bram_done  = 1'b0;
    check_quiet("idle_spur");
  endtask

  initial begin
    bus.i_c0_trig = 1'b0; bus.i_c0_addr = '0; bus.i_c0_data = '0;
    bus.i_c1_trig = 1'b0; bus.i_c1_addr = '0;
    bus.i_bram_done = 1'b0; bus.i_bram_rdata = '0;
    pend0 = 1'b0; pend1 = 1'b0; a0 = '0; a1 = '0; d0 = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    m_last_c1 = 1'b1; m_err = 1'b0; m_c1_data = '0;
    rstn = 1'b1;
    @(negedge clk);

    // simultaneous requests from reset, each client re-requesting twice in total
    pend0 = 1'b1; a0 = AW'(16'h00a0); d0 = 32'h1111_0000;
    pend1 = 1'b1; a1 = AW'(16'h00b0);
    for (int i = 0; i < 4; i++) begin
      run_xact(2, DW'($urandom), 0, gnt);
      check("rr_order", 64'(gnt), 64'(i % 2));
      if (i < 2) begin
        if (gnt) begin
          pend1 = 1'b1; a1 = AW'($urandom);
        end else begin
          pend0 = 1'b1; a0 = AW'($urandom); d0 = DW'($urandom);
        end
      end
    end

    // single write, BRAM answering 3 cycles after the client request
    pend0 = 1'b1; a0 = AW'(16'h1230); d0 = 32'h0000_0005;
    run_xact(2, '0, 0, gnt);
    check("wr_gnt", 64'(gnt), 64'(0));

    // single read
    pend1 = 1'b1; a1 = AW'(16'h0010);
    run_xact(1, 32'hDEAD_BEEF, 0, gnt);
    check("rd_data", 64'(bus.o_c1_data), 64'(32'hDEAD_BEEF));

    // client holds trig after done, then a stray BRAM done while idle
    pend0 = 1'b1; a0 = AW'($urandom); d0 = DW'($urandom);
    run_xact(0, '0, 4, gnt);
    idle_spur();

    for (int i = 0; i < 40; i++) begin
      if (!pend0 && !pend1 && ($urandom_range(0, 3) == 0)) idle_spur();
      if (!pend0 && ($urandom_range(0, 1) == 1)) begin
        pend0 = 1'b1; a0 = AW'($urandom); d0 = DW'($urandom);
      end
      if (!pend1 && ($urandom_range(0, 1) == 1)) begin
        pend1 = 1'b1; a1 = AW'($urandom);
      end
      if (!pend0 && !pend1) begin
        pend1 = 1'b1; a1 = AW'($urandom);
      end
      run_xact(int'($urandom_range(0, 11)), DW'($urandom), int'($urandom_range(0, 3)), gnt);
    end
    for (int i = 0; i < 2; i++) begin
      if (pend0 || pend1) run_xact(1, DW'($urandom), 0, gnt);
    end

    // BRAM never answers: write completes on timeout, flag stays set afterwards
    pend0 = 1'b1; a0 = AW'($urandom); d0 = DW'($urandom);
    run_xact(1000, '0, 0, gnt);
    check("tmo_err", 64'(bus.o_timeout_err), 64'(1));
    pend1 = 1'b1; a1 = AW'($urandom);
    run_xact(1, 32'hA5A5_0001, 2, gnt);

    // reset during ISSUE aborts the transaction
    pend0 = 1'b1; a0 = AW'($urandom); d0 = DW'($urandom);
    bus.i_c0_trig = 1'b1; bus.i_c0_addr = a0; bus.i_c0_data = d0;
    @(negedge clk);
    check("abort_pre_req", 64'(bus.o_bram_trig), 64'(1));
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_zero("abort");
    bus.i_c0_trig = 1'b0; pend0 = 1'b0;
    m_last_c1 = 1'b1; m_err = 1'b0; m_c1_data = '0;
    rstn = 1'b1;
    @(negedge clk);
    check_quiet("post_rst");
    pend0 = 1'b1; a0 = AW'($urandom); d0 = DW'($urandom);
    run_xact(3, '0, 1, gnt);
    check("post_rst_gnt", 64'(gnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
